ddr_burst_arbiter: RTL
======================

# ddr_burst_arbiter

Burst-level scheduler sharing the single DDR3 controller user port between the receive sample writer (ADC/demodulator FIFO) and the Ethernet transmit reader. The DDR3 region is treated as a ring buffer of fixed-size bursts. The block owns the ring pointers and fill level, and issues exactly one command at a time. It also counts the data beats of each burst before rescheduling. It sits between the receive-path FIFOs and the DDR3 controller inside RxTop.

## Interface
- BURST_LEN, 8: data beats per burst (BL8, 16-bit DQ); power of two
- ADDR_W, 28: controller column/row/bank address width, in beats
- BASE_ADDR, 0: beat address of ring slot 0; multiple of BURST_LEN
- BUF_BURSTS, 1024: ring depth in bursts; power of two, ≥2
- sys_clk  in  1  single clock for all logic
- sys_rst  in  1  synchronous, active-high reset
- wr_req  in  1  writer holds ≥1 full burst
- wr_gnt  out  1  one-cycle pulse: write command accepted
- wr_beat  out  1  writer pop strobe, one per accepted write beat
- rd_req  in  1  reader has space for ≥1 burst
- rd_gnt  out  1  one-cycle pulse: read command accepted
- rd_beat  out  1  read beat forwarded to reader (= mem_rdata_valid in RD_DATA)
- flush  in  1  empty the ring
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  controller accepts command
- mem_cmd_we  out  1  1 = write, 0 = read
- mem_cmd_addr  out  ADDR_W  beat address
- mem_wdata_ready  in  1  controller accepts one write beat
- mem_rdata_valid  in  1  controller returns one read beat
- level  out  log2(BUF_BURSTS)+1  bursts stored
- full  out  1  level == BUF_BURSTS
- empty  out  1  level == 0

## Operation
- States: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA.
- Eligibility:
  - Write is eligible when wr_req & !full.
  - Read is eligible when rd_req & !empty.
- IDLE transitions:
  - With pending flush, clear pointers and level and stay in IDLE.
  - Otherwise, if exactly one requester is eligible, go to its CMD state.
  - If both are eligible, pick the one not served last (last_wr flag, reset 0, so write wins first).
- CMD state:
  - Drive mem_cmd_valid=1, with we and addr stable until mem_cmd_ready.
  - Addr = BASE_ADDR + ptr*BURST_LEN; ptr is wr_ptr or rd_ptr.
  - On handshake, pulse the gnt output and go to the DATA state.
- WR_DATA:
  - wr_beat = mem_wdata_ready.
  - Beat counter runs 0..BURST_LEN-1.
  - On the last beat: wr_ptr++ (wraps BUF_BURSTS-1→0), level++, last_wr=1, go to IDLE.
- RD_DATA:
  - Count mem_rdata_valid beats.
  - On the last beat: rd_ptr++ (wraps), level--, last_wr=0, go to IDLE.
- Only one burst is outstanding, so level never changes from both sides in one cycle.
- flush is latched into flush_pend and acted on only in IDLE. A flush during a burst completes that burst first. flush_pend clears when applied.
- Beats arriving outside the matching DATA state are ignored; rd_beat and wr_beat stay 0.

## Timing
- Reset values:
  - All outputs 0, except empty=1.
  - mem_cmd_addr = 0.
  - State IDLE; pointers, level, counters, last_wr and flush_pend are all 0.
- Reset mid-burst aborts immediately. The writer and reader FIFOs are reset with the same sys_rst.
- Requests are sampled in IDLE; mem_cmd_valid rises the next cycle. Minimum command latency is 1 cycle after the request.
- Minimum burst period is 1 (IDLE) + 1 (CMD) + BURST_LEN (DATA) cycles, i.e. 10 with defaults.
- level, full and empty are registered and update in the cycle after the last beat.
- A request deasserted while in CMD does not cancel the command.

## Configuration
- DDR_ARB_WR_PRIORITY_EN defined:
  - Write always wins when both requesters are eligible in IDLE.
  - Reads are served only when no write is eligible.
  - Guarantees ADC capture never stalls on DDR bandwidth.
- DDR_ARB_WR_PRIORITY_EN undefined: strict alternation via last_wr, as above.

## Test plan
- Single write:
  - Stimulus: wr_req=1 with mem_cmd_ready and mem_wdata_ready always 1.
  - Response: cmd addr 0, we=1; wr_gnt at cycle 2; 8 wr_beat; level=1, empty=0.
- Fill and wrap:
  - Stimulus: BUF_BURSTS=4, 4 writes, then a 5th wr_req.
  - Response: full=1 and no 5th command.
  - Then 1 read (addr 0): after its 8 beats level=3, and the next write goes to addr 0.
- Contention:
  - Stimulus: wr_req and rd_req both held with level=2.
  - Response with macro undefined: commands alternate W,R,W,R.
  - Response with DDR_ARB_WR_PRIORITY_EN defined: W,W,W… until full.
- Backpressure:
  - Stimulus: mem_cmd_ready low for 5 cycles.
  - Response: mem_cmd_valid, we and addr held constant; one gnt pulse only at the handshake.
  - Stimulus: mem_wdata_ready toggling.
  - Response: exactly 8 wr_beat.
- Flush during read burst:
  - Stimulus: flush at read beat 3.
  - Response: burst completes with 8 rd_beat, then level=0, empty=1, next write addr = BASE_ADDR.
- Reset mid-burst:
  - Stimulus: sys_rst at write beat 4.
  - Response: next cycle all outputs at reset values; a subsequent wr_req restarts at addr 0.

Source files
------------

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
// Burst-level scheduler that shares one DDR3 controller user port between
// the receive sample writer and the Ethernet transmit reader. The DDR3
// region is a ring of BUF_BURSTS fixed-size bursts; this block owns the
// ring pointers and fill level, issues one command at a time and counts
// the data beats of each burst before it arbitrates again.
//
// Optional feature macro: DDR_ARB_WR_PRIORITY_EN
//   defined   : a write always wins when both sides are eligible, so ADC
//               capture never stalls on DDR bandwidth.
//   undefined : strict alternation between writer and reader (default).
module ddr_burst_arbiter #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned BUF_BURSTS = 1024
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          wr_req,
  output logic                          wr_gnt,
  output logic                          wr_beat,
  input  logic                          rd_req,
  output logic                          rd_gnt,
  output logic                          rd_beat,
  input  logic                          flush,
  output logic                          mem_cmd_valid,
  input  logic                          mem_cmd_ready,
  output logic                          mem_cmd_we,
  output logic [ADDR_W-1:0]             mem_cmd_addr,
  input  logic                          mem_wdata_ready,
  input  logic                          mem_rdata_valid,
  output logic [$clog2(BUF_BURSTS):0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PTR_W = $clog2(BUF_BURSTS);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(BUF_BURSTS);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    WR_DATA,
    RD_CMD,
    RD_DATA
  } state_e;

  state_e             state_q,      state_d;
  logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
  logic [LVL_W-1:0]   level_q,      level_d;
  logic [CNT_W-1:0]   beat_cnt_q,   beat_cnt_d;
  logic               last_wr_q,    last_wr_d;
  logic               flush_pend_q, flush_pend_d;
  logic               wr_gnt_q,     wr_gnt_d;
  logic               rd_gnt_q,     rd_gnt_d;

  logic               ring_full;
  logic               ring_empty;
  logic               wr_elig;
  logic               rd_elig;
  logic               pick_wr;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;

  // Fill status is derived from the registered level only.
  assign ring_full  = (level_q == LVL_FULL);
  assign ring_empty = (level_q == '0);

  assign wr_elig = wr_req & ~ring_full;
  assign rd_elig = rd_req & ~ring_empty;

`ifdef DDR_ARB_WR_PRIORITY_EN
  // Writer always wins; reads only fill the gaps.
  assign pick_wr = wr_elig;
`else
  // Writer wins alone, or on contention when the reader was served last.
  assign pick_wr = wr_elig & (~rd_elig | ~last_wr_q);
`endif

  // Beat address of the slot each pointer refers to.
  assign wr_addr = BASE + ADDR_W'(wr_ptr_q) * STRIDE;
  assign rd_addr = BASE + ADDR_W'(rd_ptr_q) * STRIDE;

  // Next-state logic: arbitration, command handshake and beat counting.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves a variable unassigned, which would infer a latch.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    beat_cnt_d   = beat_cnt_q;
    last_wr_d    = last_wr_q;
    flush_pend_d = flush_pend_q | flush;
    wr_gnt_d     = 1'b0;
    rd_gnt_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          // A flush seen in this very cycle stays pending for the next one.
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          level_d      = '0;
          flush_pend_d = flush;
        end else if (pick_wr) begin
          state_d = WR_CMD;
        end else if (rd_elig) begin
          state_d = RD_CMD;
        end
      end

      WR_CMD: begin
        if (mem_cmd_ready) begin
          wr_gnt_d = 1'b1;
          state_d  = WR_DATA;
        end
      end

      WR_DATA: begin
        if (mem_wdata_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            level_d    = level_q + LVL_W'(1);
            last_wr_d  = 1'b1;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      RD_CMD: begin
        if (mem_cmd_ready) begin
          rd_gnt_d = 1'b1;
          state_d  = RD_DATA;
        end
      end

      RD_DATA: begin
        if (mem_rdata_valid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            level_d    = level_q - LVL_W'(1);
            last_wr_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; a reset mid-burst aborts it.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    if (sys_rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      beat_cnt_q   <= '0;
      last_wr_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      wr_gnt_q     <= 1'b0;
      rd_gnt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      beat_cnt_q   <= beat_cnt_d;
      last_wr_q    <= last_wr_d;
      flush_pend_q <= flush_pend_d;
      wr_gnt_q     <= wr_gnt_d;
      rd_gnt_q     <= rd_gnt_d;
    end
  end

  // Command fields are held stable for the whole CMD state; address is 0
  // whenever no command is offered.
  assign mem_cmd_valid = (state_q == WR_CMD) | (state_q == RD_CMD);
  assign mem_cmd_we    = (state_q == WR_CMD);
  assign mem_cmd_addr  = (state_q == WR_CMD) ? wr_addr :
                         (state_q == RD_CMD) ? rd_addr : '0;

  // Beats outside the matching DATA state are ignored.
  assign wr_beat = (state_q == WR_DATA) & mem_wdata_ready;
  assign rd_beat = (state_q == RD_DATA) & mem_rdata_valid;

  assign wr_gnt = wr_gnt_q;
  assign rd_gnt = rd_gnt_q;
  assign level  = level_q;
  assign full   = ring_full;
  assign empty  = ring_empty;

endmodule
